// File: rtl/display_pkg.sv
// Shared constants and types for the two-digit 7-segment scan path:
// scan states, digit decode table and slot sizing.
package display_pkg;

  localparam int DUTY_W     = 7;
  localparam int SLOT_TICKS = 128;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DIG1  = 3'd1,
    S_GAP1  = 3'd2,
    S_DIG10 = 3'd3,
    S_GAP10 = 3'd4
  } state_e;

  // Plain-vector aliases of the scan states for the FSM register.
  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_DIG1  = S_DIG1;
  localparam logic [2:0] ST_GAP1  = S_GAP1;
  localparam logic [2:0] ST_DIG10 = S_DIG10;
  localparam logic [2:0] ST_GAP10 = S_GAP10;

  // Segment patterns ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to {dp,g,f,e,d,c,b,a} active-high segment pattern.
// Non-decimal codes and an asserted blank input both give all segments off.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = 8'h00;
    if (!blank_i && (digit_i < 4'd10)) begin
      seg_o = {1'b0, SEG_LUT[digit_i]};
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Two-digit 7-segment scan controller: digit time-multiplexing, PWM brightness
// with a frame-synchronous duty shadow, inter-digit blanking and pin polarity.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE    = 16,
  parameter int BLANK_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       display_en,
  input  logic [3:0] digit1,
  input  logic [3:0] digit10,
  input  logic       lz_blank,
  input  logic [6:0] duty_wdata,
  input  logic       duty_we,
  input  logic       seg_pol,
  input  logic       com_pol,
  output logic [7:0] seg_out,
  output logic       com1_out,
  output logic       com10_out,
  output logic [1:0] com_oe,
  output logic       frame_tick,
  output logic [2:0] dbg_state
);

  localparam int             PW        = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [6:0]     SLOT_LAST = 7'(SLOT_TICKS - 1);
  localparam logic [6:0]     GAP_LAST  = 7'(BLANK_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    state_q, state_d;
  logic [6:0]    slot_q, slot_d;
  logic [6:0]    pend_q, pend_d;
  logic [6:0]    shadow_q, shadow_d;
  logic [3:0]    digit_q, digit_d;
  logic          blank_q, blank_d;
  logic          frame_d;

  logic [7:0]    seg_q, seg_d;
  logic          com1_q, com1_d;
  logic          com10_q, com10_d;
  logic [1:0]    oe_q, oe_d;
  logic          frame_q;

  logic          tick;
  logic          in_dig;
  logic          lit;
  logic [7:0]    dec_seg;
  logic [7:0]    seg_lit;

  assign tick = (presc_q == PRE_LAST);

  seg7_decode u_dec (
    .digit_i (digit_q),
    .blank_i (blank_q),
    .seg_o   (dec_seg)
  );

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    state_d  = state_q;
    slot_d   = slot_q;
    shadow_d = shadow_q;
    digit_d  = digit_q;
    blank_d  = blank_q;
    frame_d  = 1'b0;
    // duty_we is a single-cycle strobe with no back-pressure: every strobe
    // overwrites the pending value, which only reaches the PWM at frame start.
    pend_d   = duty_we ? duty_wdata : pend_q;

    if (!display_en) begin
      state_d = ST_IDLE;
      slot_d  = '0;
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_DIG1;
          slot_d   = '0;
          shadow_d = pend_q;
          digit_d  = digit1;
          blank_d  = 1'b0;
        end
        ST_DIG1: begin
          if (slot_q == SLOT_LAST) begin
            state_d = ST_GAP1;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + 7'd1;
          end
        end
        ST_GAP1: begin
          if (slot_q == GAP_LAST) begin
            state_d = ST_DIG10;
            slot_d  = '0;
            digit_d = digit10;
            blank_d = lz_blank && (digit10 == 4'd0);
          end else begin
            slot_d = slot_q + 7'd1;
          end
        end
        ST_DIG10: begin
          if (slot_q == SLOT_LAST) begin
            state_d = ST_GAP10;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + 7'd1;
          end
        end
        ST_GAP10: begin
          if (slot_q == GAP_LAST) begin
            state_d  = ST_DIG1;
            slot_d   = '0;
            shadow_d = pend_q;
            digit_d  = digit1;
            blank_d  = 1'b0;
            frame_d  = 1'b1;
          end else begin
            slot_d = slot_q + 7'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end
      endcase
    end
  end

  // Pin outputs use display_en directly so a disable blanks the pins in the
  // same edge that sends the FSM to IDLE.
  always_comb begin
    in_dig  = display_en && ((state_q == ST_DIG1) || (state_q == ST_DIG10));
    lit     = in_dig && (slot_q < shadow_q);
    seg_lit = lit ? dec_seg : 8'h00;
    seg_d   = seg_pol ? seg_lit : ~seg_lit;
    com1_d  = (display_en && (state_q == ST_DIG1))  ? com_pol : ~com_pol;
    com10_d = (display_en && (state_q == ST_DIG10)) ? com_pol : ~com_pol;
    oe_d    = (display_en && (state_q != ST_IDLE)) ? 2'b11 : 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      state_q  <= ST_IDLE;
      slot_q   <= '0;
      pend_q   <= '0;
      shadow_q <= '0;
      digit_q  <= '0;
      blank_q  <= 1'b0;
      seg_q    <= 8'h00;
      com1_q   <= 1'b0;
      com10_q  <= 1'b0;
      oe_q     <= 2'b00;
      frame_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      state_q  <= state_d;
      slot_q   <= slot_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      digit_q  <= digit_d;
      blank_q  <= blank_d;
      seg_q    <= seg_d;
      com1_q   <= com1_d;
      com10_q  <= com10_d;
      oe_q     <= oe_d;
      frame_q  <= frame_d;
    end
  end

  assign seg_out    = seg_q;
  assign com1_out   = com1_q;
  assign com10_out  = com10_q;
  assign com_oe     = oe_q;
  assign frame_tick = frame_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: a negedge monitor summarises each frame
// and compares it against per-frame expectations queued by the stimulus.
module tb_display_scan_ctrl;

  localparam int PRESCALE    = 4;
  localparam int BLANK_TICKS = 2;
  localparam int SLOT_CLK    = 128 * PRESCALE;
  localparam int GAP_CLK     = 2 * BLANK_TICKS * PRESCALE;
  localparam int FRAME_CLK   = 2 * (128 + BLANK_TICKS) * PRESCALE;
  localparam int REC_LEN     = 11;

  logic       clk;
  logic       rst;
  logic       display_en;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic       lz_blank;
  logic [6:0] duty_wdata;
  logic       duty_we;
  logic       seg_pol;
  logic       com_pol;
  logic [7:0] seg_out;
  logic       com1_out;
  logic       com10_out;
  logic [1:0] com_oe;
  logic       frame_tick;
  logic [2:0] dbg_state;

  logic [31:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  display_scan_ctrl #(
    .PRESCALE    (PRESCALE),
    .BLANK_TICKS (BLANK_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .display_en (display_en),
    .digit1     (digit1),
    .digit10    (digit10),
    .lz_blank   (lz_blank),
    .duty_wdata (duty_wdata),
    .duty_we    (duty_we),
    .seg_pol    (seg_pol),
    .com_pol    (com_pol),
    .seg_out    (seg_out),
    .com1_out   (com1_out),
    .com10_out  (com10_out),
    .com_oe     (com_oe),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_seg(input logic [3:0] d);
    case (d)
      4'd0: tb_seg = 8'h3F;
      4'd1: tb_seg = 8'h06;
      4'd2: tb_seg = 8'h5B;
      4'd3: tb_seg = 8'h4F;
      4'd4: tb_seg = 8'h66;
      4'd5: tb_seg = 8'h6D;
      4'd6: tb_seg = 8'h7D;
      4'd7: tb_seg = 8'h07;
      4'd8: tb_seg = 8'h7F;
      4'd9: tb_seg = 8'h6F;
      default: tb_seg = 8'h00;
    endcase
  endfunction

  function automatic string tag_of(input int i);
    case (i)
      0: tag_of = "frame_period";
      1: tag_of = "com1_clks";
      2: tag_of = "ones_lit_clks";
      3: tag_of = "ones_pattern";
      4: tag_of = "com10_clks";
      5: tag_of = "tens_lit_clks";
      6: tag_of = "tens_pattern";
      7: tag_of = "gap_clks";
      8: tag_of = "gap_off_clks";
      9: tag_of = "com_overlap";
      default: tag_of = "com_oe_not_11";
    endcase
  endfunction

  // Expected frame summary from the digit/duty/polarity model.
  task automatic push_frame(input int duty, input logic [3:0] d1, input logic [3:0] d10,
                            input logic lz, input logic spol);
    logic [7:0] s1, s10, off;
    s1  = tb_seg(d1);
    s10 = (lz && d10 == 4'd0) ? 8'h00 : tb_seg(d10);
    off = {8{~spol}};
    exp_q.push_back(FRAME_CLK);
    exp_q.push_back(SLOT_CLK);
    exp_q.push_back((duty == 0 || s1 == 8'h00) ? 0 : duty * PRESCALE);
    exp_q.push_back({24'h0, (duty == 0 || s1 == 8'h00) ? off : (spol ? s1 : ~s1)});
    exp_q.push_back(SLOT_CLK);
    exp_q.push_back((duty == 0 || s10 == 8'h00) ? 0 : duty * PRESCALE);
    exp_q.push_back({24'h0, (duty == 0 || s10 == 8'h00) ? off : (spol ? s10 : ~s10)});
    exp_q.push_back(GAP_CLK);
    exp_q.push_back(GAP_CLK);
    exp_q.push_back(0);
    exp_q.push_back(0);
  endtask

  task automatic write_duty(input logic [6:0] v);
    duty_wdata = v;
    duty_we    = 1'b1;
    @(posedge clk);
    #1 duty_we = 1'b0;
  endtask

  // Returns just after the negedge where frame_tick is seen high.
  task automatic wait_frame();
    logic got;
    got = 1'b0;
    for (int i = 0; i < FRAME_CLK + 160; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("frame_arrival", {31'h0, got}, 32'd1);
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int m_per, m_c1, m_l1, m_c10, m_l10, m_gap, m_goff, m_both, m_oe;
  logic [7:0] m_p1, m_p10;

  task automatic clear_mon();
    m_per = 0; m_c1 = 0; m_l1 = 0; m_c10 = 0; m_l10 = 0;
    m_gap = 0; m_goff = 0; m_both = 0; m_oe = 0;
    m_p1  = {8{~seg_pol}};
    m_p10 = {8{~seg_pol}};
  endtask

  initial begin : monitor
    logic [7:0]  off;
    logic        a1, a10;
    logic [31:0] obs [0:REC_LEN-1];
    clear_mon();
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        clear_mon();
      end else begin
        off = {8{~seg_pol}};
        a1  = (com1_out === com_pol);
        a10 = (com10_out === com_pol);
        m_per++;
        if (a1) begin
          m_c1++;
          if (seg_out !== off) begin m_l1++; m_p1 = seg_out; end
        end
        if (a10) begin
          m_c10++;
          if (seg_out !== off) begin m_l10++; m_p10 = seg_out; end
        end
        if (!a1 && !a10) begin
          m_gap++;
          if (seg_out === off) m_goff++;
        end
        if (a1 && a10) m_both++;
        if (com_oe !== 2'b11) m_oe++;
        if (frame_tick === 1'b1) begin
          if (exp_q.size() >= REC_LEN) begin
            obs[0]  = m_per;   obs[1] = m_c1;  obs[2] = m_l1;
            obs[3]  = {24'h0, m_p1};
            obs[4]  = m_c10;   obs[5] = m_l10;
            obs[6]  = {24'h0, m_p10};
            obs[7]  = m_gap;   obs[8] = m_goff; obs[9] = m_both;
            obs[10] = m_oe;
            for (int i = 0; i < REC_LEN; i++) check(tag_of(i), obs[i], exp_q.pop_front());
          end
          clear_mon();
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic found;
    int   lit;
    rst = 1'b1; display_en = 1'b0; digit1 = 4'd0; digit10 = 4'd0; lz_blank = 1'b0;
    duty_wdata = 7'd0; duty_we = 1'b0; seg_pol = 1'b1; com_pol = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_seg_out", {24'h0, seg_out}, 32'h00);
    check("rst_com1", {31'h0, com1_out}, 32'd0);
    check("rst_com10", {31'h0, com10_out}, 32'd0);
    check("rst_com_oe", {30'h0, com_oe}, 32'd0);
    check("rst_frame_tick", {31'h0, frame_tick}, 32'd0);
    check("rst_state", {29'h0, dbg_state}, 32'd0);

    @(negedge clk) rst = 1'b0;
    write_duty(7'd127);
    digit1 = 4'd4; digit10 = 4'd2; display_en = 1'b1;

    // Frame A at duty 127; write 32 in the middle of its ones slot.
    wait_frame();
    push_frame(127, 4'd4, 4'd2, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    write_duty(7'd32);

    // Frame B at 32; a write in the frame_tick cycle waits one more frame.
    wait_frame();
    write_duty(7'd0);
    push_frame(32, 4'd4, 4'd2, 1'b0, 1'b1);

    // Frame C dark; stage duty 127 and leading-zero digits for later frames.
    wait_frame();
    push_frame(0, 4'd4, 4'd2, 1'b0, 1'b1);
    write_duty(7'd127);
    digit1 = 4'd7; digit10 = 4'd0; lz_blank = 1'b1;

    wait_frame();
    push_frame(127, 4'd7, 4'd0, 1'b1, 1'b1);
    digit1 = 4'd12;

    wait_frame();
    push_frame(127, 4'd12, 4'd0, 1'b1, 1'b1);

    // Inverted polarity; the transition frame is skipped.
    wait_frame();
    seg_pol = 1'b0; com_pol = 1'b0;
    digit1 = 4'd4; digit10 = 4'd2; lz_blank = 1'b0;
    wait_frame();
    push_frame(127, 4'd4, 4'd2, 1'b0, 1'b0);

    wait_frame();
    seg_pol = 1'b1; com_pol = 1'b1;
    repeat (700) @(negedge clk);
    check("tens_active_pre_disable", {31'h0, com10_out}, 32'd1);
    display_en = 1'b0;
    @(negedge clk);
    check("dis_com_oe", {30'h0, com_oe}, 32'd0);
    check("dis_seg_out", {24'h0, seg_out}, 32'h00);
    check("dis_com1", {31'h0, com1_out}, 32'd0);
    check("dis_com10", {31'h0, com10_out}, 32'd0);
    check("dis_state", {29'h0, dbg_state}, 32'd0);
    write_duty(7'd64);
    repeat (20) @(negedge clk);
    check("dis_com_oe_hold", {30'h0, com_oe}, 32'd0);

    display_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (com1_out === 1'b1) begin found = 1'b1; break; end
    end
    check("reenable_dig1", {31'h0, found}, 32'd1);
    lit = 0;
    for (int i = 0; i < 300; i++) begin
      if (seg_out === 8'h66 && com1_out === 1'b1) lit++;
      @(negedge clk);
    end
    check("reenable_duty_clks", lit, 64 * PRESCALE);

    // Asynchronous reset in the middle of the ones slot.
    check("pre_rst_com_oe", {30'h0, com_oe}, 32'd3);
    #3 rst = 1'b1;
    #1;
    check("arst_seg_out", {24'h0, seg_out}, 32'h00);
    check("arst_com1", {31'h0, com1_out}, 32'd0);
    check("arst_com10", {31'h0, com10_out}, 32'd0);
    check("arst_com_oe", {30'h0, com_oe}, 32'd0);
    check("arst_frame_tick", {31'h0, frame_tick}, 32'd0);
    check("arst_state", {29'h0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Pending and shadow duty were cleared: the digit scans dark.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (com1_out === 1'b1) begin found = 1'b1; break; end
    end
    check("post_rst_dig1", {31'h0, found}, 32'd1);
    check("post_rst_com_oe", {30'h0, com_oe}, 32'd3);
    lit = 0;
    for (int i = 0; i < 100; i++) begin
      if (seg_out !== 8'h00) lit++;
      @(negedge clk);
    end
    check("post_rst_dark", lit, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing and brightness controller for the two-digit common-anode/cathode 7-segment display of the dice design. It takes the BCD ones/tens digits from the dice core and a 7-bit duty value written over I2C (register 8, bits 6:0). It sequences the two digit commons, applies PWM brightness and inter-digit blanking, and drives segment/common pins with configurable polarity. The block sits between the dice/I2C register file and the uo_out / uio_out[4:3] pads.

## Interface
- PRESCALE, default 16: clocks per PWM tick, ≥2.
- BLANK_TICKS, default 4: all-off ticks after each digit slot, ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- display_en  in  1  enables scanning; low forces IDLE.
- digit1  in  4  ones BCD value; 10–15 displays blank.
- digit10  in  4  tens BCD value; 10–15 displays blank.
- lz_blank  in  1  blank the tens digit when digit10==0.
- duty_wdata  in  7  brightness, on-ticks out of 128; 0 = dark.
- duty_we  in  1  one-cycle write strobe for duty_wdata.
- seg_pol  in  1  segment-on level (uio_in[6]).
- com_pol  in  1  common-active level (uio_in[7]).
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}; dp is always off.
- com1_out  out  1  ones common.
- com10_out  out  1  tens common.
- com_oe  out  2  {tens, ones} common output enables.
- frame_tick  out  1  one-cycle pulse at end of each frame.

## Operation
- Prescaler: counts 0..PRESCALE-1; tick asserts in the cycle the prescaler reads PRESCALE-1. All FSM and slot-counter advances occur only on tick.
- FSM states IDLE, DIG1, GAP1, DIG10, GAP10.
  - IDLE → DIG1 on a tick with display_en=1.
  - DIG1 → GAP1 after 128 ticks. GAP1 → DIG10 after BLANK_TICKS ticks.
  - DIG10 → GAP10 after 128 ticks. GAP10 → DIG1 after BLANK_TICKS ticks.
- Slot counter: 7 bits, cleared on every state entry. In DIG states it wraps 127→0 exactly when the state changes.
- Duty shadow: duty_we loads a pending register. The pending value is copied to the shadow on IDLE→DIG1 and on GAP10→DIG1 only. A write in the same cycle as that transfer is used from the following frame.
- Segment pattern in DIG states:
  - Lit while slot_cnt < shadow_duty, with pattern = decode(digit); otherwise all off.
  - Digits are sampled on entry to each DIG state and held for the slot.
  - Digit 10–15 decodes to all-off. Tens decodes to all-off when lz_blank && digit10==0.
- Decode (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Pin levels:
  - A lit segment drives seg_pol, an unlit segment drives ~seg_pol.
  - An active common drives com_pol, an inactive common drives ~com_pol.
  - com1 is active only in DIG1, com10 only in DIG10.
  - com_oe=11 in every state except IDLE, where it is 00.
- display_en low: the FSM goes to IDLE in the next clock, without waiting for a tick. All segments and commons go inactive, and com_oe goes to 00.
- frame_tick: one-cycle pulse registered with the GAP10→DIG1 transition.

## Timing
- All outputs are registered: one clock from the state/counter change to the pins.
- Reset values: seg_out=00, com1_out=0, com10_out=0, com_oe=00, frame_tick=0.
- After reset the internal state is:
  - state IDLE, prescaler 0, slot counter 0, pending duty 0, shadow duty 0.
- Frame length = 2·(128+BLANK_TICKS)·PRESCALE clocks. Each digit is on for duty·PRESCALE clocks per frame.
- Overlap: both commons are never simultaneously active in any cycle, including during a polarity change.
- seg_pol/com_pol are treated as static. A change takes effect on the next registered output cycle.
- Reset asserted mid-frame: outputs return to their reset values asynchronously.

## Structure
- Package display_pkg: state enum, the decode constant array SEG_LUT[0:9], and the DUTY_W=7 and SLOT_TICKS=128 constants.
- One natural sub-module: seg7_decode (combinational 4→8 decode with blank input), shared with any future display path.
- Prescaler, FSM, slot counter and output registers stay in display_scan_ctrl.

## Test plan
- PRESCALE=4, BLANK_TICKS=2, duty write 127, digits 4/2, pols 1/1.
  - Required: frame_tick period 1040 clocks.
  - Required: ones pattern 66 for 508 clocks of its 512-clock slot; tens pattern 5B likewise.
  - Required: 8 all-off clocks per gap, and com1/com10 never both 1.
- Duty 0: commons still scan, com_oe=11, seg_out stays at all-off level for the whole frame.
- Duty write 32 mid-DIG1 while shadow=127: the current frame stays at 127-tick on-time; the next frame has a 32-tick (128-clock) on-time. Also pulse duty_we in the frame_tick cycle: the new value appears one frame later.
- lz_blank=1, digit10=0, digit1=7: tens slot segments all-off, ones slot 07. With digit1=12: ones slot all-off.
- seg_pol=0, com_pol=0: pins are the bitwise inverse of the scenario-1 waveforms.
- display_en dropped mid-DIG10, then rst pulsed mid-DIG1:
  - After display_en drops, the next clock has com_oe=00 and all pins inactive.
  - Re-enable restarts at DIG1 with the pending duty applied.
  - rst immediately gives all outputs 0.
